// File: rtl/nios2_oci_fifo_rdptr_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_oci_fifo_rdptr_ctrl
//
// Read-side controller for the OCI trace FIFO. It tracks the fill level from
// the writer's per-cycle increment and owns the read pointer into the
// register-file FIFO. It presents the head entry on a registered valid/ready
// trace word port, and it reports the free-space flags that the write-pointer
// logic consumes.
//
// Ports:
//   clk             core clock
//   reset_n         synchronous active-low reset (highest priority)
//   trc_clear       synchronous flush of FIFO state and output stage (tw data kept)
//   fifo_wrptr_inc  entries written this cycle (legal 0..3)
//   fifo_rdata      register-file word at fifo_rdptr (combinational read)
//   fifo_rdptr      current read pointer
//   tw / tw_valid   registered trace word and its valid flag
//   tw_ready        downstream accepts tw this cycle
//   fifo_cnt        entries stored in the FIFO (0..DEPTH), tw register excluded
//   fifo_empty      fifo_cnt == 0
//   ge2_free        at least two free entries
//   ge3_free        at least three free entries
//   overflow        sticky: the writer exceeded the free space
//
// DEPTH must be a power of two with AW == log2(DEPTH); the read pointer
// relies on natural AW-bit wrap.
// ---------------------------------------------------------------------------
module nios2_oci_fifo_rdptr_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 36
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trc_clear,
    input  logic [3:0]    fifo_wrptr_inc,
    input  logic [DW-1:0] fifo_rdata,
    output logic [AW-1:0] fifo_rdptr,
    output logic [DW-1:0] tw,
    output logic          tw_valid,
    input  logic          tw_ready,
    output logic [AW:0]   fifo_cnt,
    output logic          fifo_empty,
    output logic          ge2_free,
    output logic          ge3_free,
    output logic          overflow
);

    // Count width (0..DEPTH) and the wider arithmetic width; the wider width
    // leaves headroom for an illegal increment on a full FIFO.
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = AW + 2;

    // Registered state
    logic [AW-1:0] r_rdptr;
    logic [DW-1:0] r_tw;
    logic          r_tw_valid;
    logic [CW-1:0] r_cnt;
    logic          r_overflow;

    // Next-state and helper nets
    logic [AW-1:0] w_rdptr_nxt;
    logic [DW-1:0] w_tw_nxt;
    logic          w_tw_valid_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_overflow_nxt;
    logic          w_empty;
    logic          w_pop;
    logic [NW-1:0] w_cnt_sum;

    // Status flags look only at the registered count (no same-cycle pop credit)
    assign w_empty = (r_cnt == '0);

    // Advance the head whenever the output stage is free or being drained
    assign w_pop = !w_empty && (!r_tw_valid || tw_ready);

    // Fill level after this cycle's writes and pop; pop can never underflow
    // because it requires a non-empty FIFO.
    assign w_cnt_sum = NW'(r_cnt) + NW'(fifo_wrptr_inc) - NW'(w_pop);

    // Next-state logic
    always_comb begin
        w_rdptr_nxt    = r_rdptr;
        w_tw_nxt       = r_tw;
        w_tw_valid_nxt = r_tw_valid;
        w_cnt_nxt      = r_cnt;
        w_overflow_nxt = r_overflow;

        if (trc_clear) begin
            // Flush drops the write increment too; tw data is left as-is
            w_rdptr_nxt    = '0;
            w_tw_valid_nxt = 1'b0;
            w_cnt_nxt      = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_pop) begin
                w_tw_nxt       = fifo_rdata;
                w_tw_valid_nxt = 1'b1;
                w_rdptr_nxt    = r_rdptr + AW'(1);
            end else if (tw_ready) begin
                w_tw_valid_nxt = 1'b0;
            end

            // Saturate at DEPTH; entries are never dropped here, only flagged
            if (w_cnt_sum > NW'(DEPTH)) begin
                w_cnt_nxt      = CW'(DEPTH);
                w_overflow_nxt = 1'b1;
            end else begin
                w_cnt_nxt      = CW'(w_cnt_sum);
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdptr    <= '0;
            r_tw       <= '0;
            r_tw_valid <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rdptr    <= w_rdptr_nxt;
            r_tw       <= w_tw_nxt;
            r_tw_valid <= w_tw_valid_nxt;
            r_cnt      <= w_cnt_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Outputs
    assign fifo_rdptr = r_rdptr;
    assign tw         = r_tw;
    assign tw_valid   = r_tw_valid;
    assign fifo_cnt   = r_cnt;
    assign overflow   = r_overflow;
    assign fifo_empty = w_empty;
    assign ge2_free   = (r_cnt <= CW'(DEPTH - 2));
    assign ge3_free   = (r_cnt <= CW'(DEPTH - 3));

endmodule

// File: tb/tb_nios2_oci_fifo_rdptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios2_oci_fifo_rdptr_ctrl
//
// Directed bench for the OCI trace FIFO read controller. The bench plays the
// writer: it owns a 16-entry register file and a write pointer, stores a
// running sequence number in each written slot, and compares the DUT outputs
// against hand-computed values one cycle at a time.
// ---------------------------------------------------------------------------
module tb_nios2_oci_fifo_rdptr_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 36;

    logic          clk;
    logic          reset_n;
    logic          trc_clear;
    logic [3:0]    fifo_wrptr_inc;
    logic [DW-1:0] fifo_rdata;
    logic [AW-1:0] fifo_rdptr;
    logic [DW-1:0] tw;
    logic          tw_valid;
    logic          tw_ready;
    logic [AW:0]   fifo_cnt;
    logic          fifo_empty;
    logic          ge2_free;
    logic          ge3_free;
    logic          overflow;

    // Writer-side model
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    int            seq;

    int n_checks;
    int n_errors;

    assign fifo_rdata = mem[fifo_rdptr];

    nios2_oci_fifo_rdptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trc_clear      (trc_clear),
        .fifo_wrptr_inc (fifo_wrptr_inc),
        .fifo_rdata     (fifo_rdata),
        .fifo_rdptr     (fifo_rdptr),
        .tw             (tw),
        .tw_valid       (tw_valid),
        .tw_ready       (tw_ready),
        .fifo_cnt       (fifo_cnt),
        .fifo_empty     (fifo_empty),
        .ge2_free       (ge2_free),
        .ge3_free       (ge3_free),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write n entries this cycle and advance one clock
    task automatic wr_tick(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = DW'(seq);
            wp      = wp + AW'(1);
            seq     = seq + 1;
        end
        fifo_wrptr_inc = 4'(n);
        tick();
        fifo_wrptr_inc = 4'd0;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        trc_clear      = 1'b0;
        fifo_wrptr_inc = 4'd0;
        tw_ready       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wp      = '0;
        seq     = 0;
    endtask

    // Reach fifo_cnt=7, tw_valid=1, overflow=1 with tw holding entry 9
    task automatic setup_flush();
        do_reset();
        for (int i = 0; i < 6; i++) wr_tick(3);
        chk("fl_setup_cnt16", 64'(fifo_cnt), 64'd16);
        chk("fl_setup_ovf",   64'(overflow), 64'd1);
        tw_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        tw_ready = 1'b0;
        chk("fl_setup_cnt7",  64'(fifo_cnt),   64'd7);
        chk("fl_setup_valid", 64'(tw_valid),   64'd1);
        chk("fl_setup_ovf2",  64'(overflow),   64'd1);
        chk("fl_setup_tw",    64'(tw),         64'd9);
        chk("fl_setup_rdptr", 64'(fifo_rdptr), 64'd10);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        wp  = '0;
        seq = 0;

        // Reset then idle
        do_reset();
        tick();
        chk("rst_rdptr", 64'(fifo_rdptr), 64'd0);
        chk("rst_cnt",   64'(fifo_cnt),   64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_ge2",   64'(ge2_free),   64'd1);
        chk("rst_ge3",   64'(ge3_free),   64'd1);
        chk("rst_valid", 64'(tw_valid),   64'd0);
        chk("rst_ovf",   64'(overflow),   64'd0);
        chk("rst_tw",    64'(tw),         64'd0);

        // Write three, drain with tw_ready=1
        tw_ready = 1'b1;
        wr_tick(3);
        chk("wd_cnt3",   64'(fifo_cnt), 64'd3);
        chk("wd_valid0", 64'(tw_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wd_cnt",   64'(fifo_cnt), 64'(2 - k));
            chk("wd_tw",    64'(tw),       64'(k));
            chk("wd_valid", 64'(tw_valid), 64'd1);
        end
        tick();
        chk("wd_valid_end", 64'(tw_valid),   64'd0);
        chk("wd_rdptr_end", 64'(fifo_rdptr), 64'd3);
        chk("wd_empty_end", 64'(fifo_empty), 64'd1);

        // Backpressure: 5 entries, tw_ready low for 4 cycles
        tw_ready = 1'b0;
        wr_tick(3);
        chk("bp_cnt3", 64'(fifo_cnt), 64'd3);
        wr_tick(2);
        chk("bp_cnt4", 64'(fifo_cnt), 64'd4);
        chk("bp_tw3",  64'(tw),       64'd3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_valid", 64'(tw_valid), 64'd1);
            chk("bp_hold_tw",    64'(tw),       64'd3);
            chk("bp_hold_cnt",   64'(fifo_cnt), 64'd4);
        end
        tw_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_drain_valid", 64'(tw_valid), 64'd1);
            chk("bp_drain_tw",    64'(tw),       64'(4 + k));
            chk("bp_drain_cnt",   64'(fifo_cnt), 64'(3 - k));
        end
        tick();
        chk("bp_valid_end", 64'(tw_valid),   64'd0);
        chk("bp_rdptr_end", 64'(fifo_rdptr), 64'd8);

        // Free flags and overflow
        tw_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr_tick(3);
        chk("ff_cnt14", 64'(fifo_cnt), 64'd14);
        chk("ff_ge2_14", 64'(ge2_free), 64'd1);
        chk("ff_ge3_14", 64'(ge3_free), 64'd0);
        chk("ff_tw8",   64'(tw),       64'd8);
        wr_tick(2);
        chk("ff_cnt16",  64'(fifo_cnt),   64'd16);
        chk("ff_ge2_16", 64'(ge2_free),   64'd0);
        chk("ff_ge3_16", 64'(ge3_free),   64'd0);
        chk("ff_ovf_16", 64'(overflow),   64'd0);
        chk("ff_empty",  64'(fifo_empty), 64'd0);
        wr_tick(1);
        chk("ff_cnt_sat", 64'(fifo_cnt), 64'd16);
        chk("ff_ovf_set", 64'(overflow), 64'd1);
        tw_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        chk("ff_drain_cnt",   64'(fifo_cnt), 64'd0);
        chk("ff_drain_valid", 64'(tw_valid), 64'd0);
        chk("ff_ovf_sticky",  64'(overflow), 64'd1);

        // Wrap with one write per cycle and continuous drain
        do_reset();
        tw_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_tick(1);
            chk("wr_cnt",   64'(fifo_cnt),   64'd1);
            chk("wr_rdptr", 64'(fifo_rdptr), 64'(k % 16));
            if (k >= 1) begin
                chk("wr_valid", 64'(tw_valid), 64'd1);
                chk("wr_tw",    64'(tw),       64'(k - 1));
            end
        end
        tick();
        chk("wr_last_tw",  64'(tw),         64'd39);
        chk("wr_last_cnt", 64'(fifo_cnt),   64'd0);
        chk("wr_rdptr40",  64'(fifo_rdptr), 64'd8);
        tick();
        chk("wr_valid_end", 64'(tw_valid), 64'd0);
        chk("wr_ovf",       64'(overflow), 64'd0);

        // Flush mid-stream: write increment discarded, tw data kept
        setup_flush();
        trc_clear      = 1'b1;
        fifo_wrptr_inc = 4'd2;
        tick();
        trc_clear      = 1'b0;
        fifo_wrptr_inc = 4'd0;
        wp             = '0;
        seq            = 0;
        chk("fl_cnt",   64'(fifo_cnt),   64'd0);
        chk("fl_rdptr", 64'(fifo_rdptr), 64'd0);
        chk("fl_valid", 64'(tw_valid),   64'd0);
        chk("fl_ovf",   64'(overflow),   64'd0);
        chk("fl_tw",    64'(tw),         64'd9);
        chk("fl_empty", 64'(fifo_empty), 64'd1);
        tick();
        chk("fl_cnt_after",   64'(fifo_cnt), 64'd0);
        chk("fl_valid_after", 64'(tw_valid), 64'd0);

        // Flush together with reset: same clearing, tw zeroed
        setup_flush();
        reset_n        = 1'b0;
        trc_clear      = 1'b1;
        fifo_wrptr_inc = 4'd2;
        tick();
        reset_n        = 1'b1;
        trc_clear      = 1'b0;
        fifo_wrptr_inc = 4'd0;
        chk("flr_cnt",   64'(fifo_cnt),   64'd0);
        chk("flr_rdptr", 64'(fifo_rdptr), 64'd0);
        chk("flr_valid", 64'(tw_valid),   64'd0);
        chk("flr_ovf",   64'(overflow),   64'd0);
        chk("flr_tw",    64'(tw),         64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios2_oci_fifo_rdptr_ctrl.md
Name: nios2_oci_fifo_rdptr_ctrl

Overview:
Read-side controller for the 16-entry OCI trace FIFO. It tracks the FIFO fill level from the writer's per-cycle increment and drives the read pointer into the register-file FIFO. It streams entries out through a registered valid/ready trace word port. It also generates the ge2_free/ge3_free flags that the write-pointer logic consumes.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two
AW, 4, pointer width, log2(DEPTH)
DW, 36, trace word width

Ports:
clk  input  1  core clock
reset_n  input  1  synchronous active-low reset
trc_clear  input  1  synchronous flush of FIFO state and output stage
fifo_wrptr_inc  input  4  entries written this cycle (legal 0..3)
fifo_rdata  input  DW  FIFO word at fifo_rdptr (combinational register-file read)
fifo_rdptr  output  AW  current read pointer
tw  output  DW  registered trace word
tw_valid  output  1  tw holds a valid entry
tw_ready  input  1  downstream accepts tw this cycle
fifo_cnt  output  AW+1  entries stored (0..DEPTH), excludes tw register
fifo_empty  output  1  fifo_cnt == 0
ge2_free  output  1  (DEPTH - fifo_cnt) >= 2
ge3_free  output  1  (DEPTH - fifo_cnt) >= 3
overflow  output  1  sticky: writer exceeded free space

Behaviour:
- Reset (reset_n=0 at clk edge): fifo_rdptr=0, fifo_cnt=0, tw=0, tw_valid=0, overflow=0. Reset has priority over everything else.
- trc_clear=1 (reset_n=1): same clearing as reset, except tw keeps its value and tw_valid=0. The same-cycle fifo_wrptr_inc is discarded.
- pop = !fifo_empty && (!tw_valid || tw_ready). This is combinational from registered state.
- Pop cycle:
  - tw <= fifo_rdata, tw_valid <= 1.
  - fifo_rdptr <= fifo_rdptr + 1, wrapping 15->0 (mod DEPTH).
- No pop and tw_ready=1: tw_valid <= 0 (tw data held).
- No pop and tw_ready=0: tw and tw_valid held.
- Handshake rules:
  - A transfer occurs when tw_valid && tw_ready.
  - tw and tw_valid must not change while tw_valid=1 and tw_ready=0.
  - Sustained tw_ready=1 gives one entry per cycle with no bubbles.
- Read latency: an entry is written at edge N and counted in fifo_cnt after edge N. If tw is empty it can pop in cycle N+1 and appears on tw after edge N+1.
- Count update, computed in AW+2-bit unsigned: next = fifo_cnt + fifo_wrptr_inc - pop.
  - If next > DEPTH: fifo_cnt <= DEPTH and overflow <= 1.
  - Otherwise fifo_cnt <= next.
- Simultaneous write and pop in the same cycle are both honoured.
- fifo_empty, ge2_free and ge3_free are combinational from registered fifo_cnt. They do not credit a same-cycle pop.
- overflow stays set until reset or trc_clear. Entries are never dropped by this block; writer data corruption past DEPTH is the writer's responsibility.
- fifo_wrptr_inc values 4..15 are illegal. The block applies them arithmetically anyway, so overflow typically sets.
- The write pointer is not owned here. Writer and reader pointers stay consistent because both start at 0 on reset/trc_clear.

Test Plan:
- Reset then idle: after reset, fifo_rdptr=0, fifo_cnt=0, fifo_empty=1, ge2_free=ge3_free=1, tw_valid=0, overflow=0.
- Write then drain, tw_ready=1:
  - Stimulus: inc=3 for one cycle, fifo_rdata=pointer index.
  - Required: fifo_cnt goes 3,2,1,0 (one pop per cycle); tw shows 0,1,2 on consecutive cycles; fifo_rdptr ends at 3.
- Backpressure:
  - Stimulus: fill 5 entries, hold tw_ready=0 for 4 cycles.
  - Required: tw_valid=1 and tw constant; fifo_cnt=4 steady. Releasing tw_ready drains the rest with no gaps.
- Free flags and overflow:
  - Stimulus: fill to 14, then inc=2; check flags; then inc=1.
  - Required: at 14, ge2_free=1, ge3_free=0. At 16, ge2_free=0 and overflow=0. On inc=1 with no pop, fifo_cnt stays 16 and overflow=1, sticky across later drains.
- Wrap and simultaneous events:
  - Stimulus: stream 40 entries with inc=1 every cycle and tw_ready=1.
  - Required: fifo_cnt stays 0..1; fifo_rdptr wraps 15->0; tw order is preserved.
- Flush mid-stream:
  - Stimulus: assert trc_clear with fifo_cnt=7, tw_valid=1, overflow=1, inc=2.
  - Required: next cycle fifo_cnt=0, fifo_rdptr=0, tw_valid=0, overflow=0, and the inc is ignored. Asserting reset_n=0 in the same cycle gives the same result with tw=0.
